// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_pkg
//  Brief    : Shared event-type encodings and index-width helper for the
//             button event arbiter and its round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

    // Event type encodings presented on evt_type (2'b11 is never produced)
    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;

    // Width of a channel index; never less than one bit
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Round-robin selector. Searches the request vector starting at
//             the channel after the last granted one and returns a one-hot
//             grant plus its index. The pointer moves to the granted channel
//             when i_en is asserted.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import button_pkg::*;
#(
    parameter int  C_CHANNELS = 4,
    localparam int CW         = chan_width(C_CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [C_CHANNELS-1:0] i_req,
    input  logic                  i_en,
    output logic [C_CHANNELS-1:0] o_gnt,
    output logic [CW-1:0]         o_idx,
    output logic                  o_any
);

    logic [CW-1:0]         r_ptr;
    logic [C_CHANNELS-1:0] w_gnt;
    logic [CW-1:0]         w_idx;
    logic                  w_any;
    logic [CW:0]           w_sum;
    logic [CW-1:0]         w_pos;

    // First requester found walking forward from the channel after r_ptr
    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        w_any = 1'b0;
        w_sum = '0;
        w_pos = '0;
        for (int k = 1; k <= C_CHANNELS; k++) begin
            w_sum = {1'b0, r_ptr} + (CW+1)'(k);
            if (w_sum >= (CW+1)'(C_CHANNELS)) begin
                w_sum = w_sum - (CW+1)'(C_CHANNELS);
            end
            w_pos = w_sum[CW-1:0];
            if (!w_any && i_req[w_pos]) begin
                w_any        = 1'b1;
                w_gnt[w_pos] = 1'b1;
                w_idx        = w_pos;
            end
        end
    end

    // Pointer tracks the last granted channel; reset value makes channel 0 first
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ptr <= CW'(C_CHANNELS - 1);
        end else if (i_en && w_any) begin
            r_ptr <= w_idx;
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;
    assign o_any = w_any;

endmodule
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_arbiter
//  Brief    : Turns debounced button levels into press / release (and
//             optionally long-press) events, queues one pending event of each
//             kind per channel, and presents them one at a time on a
//             valid/ready port using round-robin channel selection. Events
//             arriving while the same kind is still pending set a sticky
//             per-channel overrun flag.
//  Options  : BUTTON_EVENT_LONGPRESS_EN - adds per-channel hold counters and
//             long-press events after C_LONG_MS of continuous press.
//  Revision : 1.0 - initial release
// ============================================================================
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int  C_CHANNELS = 4,
    parameter int  C_CLK_FRQ  = 100000000,
    parameter int  C_LONG_MS  = 1000,
    localparam int CW         = chan_width(C_CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [C_CHANNELS-1:0] btn_in,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [CW-1:0]         evt_chan,
    output logic [1:0]            evt_type,
    output logic [C_CHANNELS-1:0] overrun,
    input  logic                  ovr_clr
);

    // 64-bit product: the default clock times the default threshold overflows 32 bits
    localparam longint C_LONG_CYCLES = longint'(C_CLK_FRQ) * longint'(C_LONG_MS) / 64'sd1000;

    if (C_CHANNELS < 2 || C_CHANNELS > 16 || C_LONG_CYCLES < 1) begin : g_cfg_check
        $error("button_event_arbiter: unsupported parameter set");
    end

    logic [C_CHANNELS-1:0] r_btn_q;
    logic [C_CHANNELS-1:0] r_press;
    logic [C_CHANNELS-1:0] r_rel;
    logic [C_CHANNELS-1:0] r_ovr;
    logic                  r_valid;
    logic [CW-1:0]         r_chan;
    logic [1:0]            r_type;

    logic [C_CHANNELS-1:0] w_rise;
    logic [C_CHANNELS-1:0] w_fall;
    logic                  w_hs;
    logic                  w_load;
    logic [C_CHANNELS-1:0] w_chan_oh;
    logic [C_CHANNELS-1:0] w_press_eff;
    logic [C_CHANNELS-1:0] w_rel_eff;
    logic [C_CHANNELS-1:0] w_long_eff;
    logic [C_CHANNELS-1:0] w_long_ovr;
    logic [C_CHANNELS-1:0] w_req;
    logic [C_CHANNELS-1:0] w_gnt;
    logic [CW-1:0]         w_idx;
    logic                  w_any;
    logic [1:0]            w_sel_type;
    logic [C_CHANNELS-1:0] w_ovr_set;

    assign w_rise    = btn_in & ~r_btn_q;
    assign w_fall    = ~btn_in & r_btn_q;
    assign w_hs      = r_valid & evt_ready;
    assign w_load    = ~r_valid | evt_ready;
    assign w_chan_oh = C_CHANNELS'(1) << r_chan;

    // Pending bits with the event being accepted this cycle already removed;
    // the arbiter only looks at these so the next grant never repeats it
    assign w_press_eff = r_press & ~((w_hs && r_type == EVT_PRESS)   ? w_chan_oh : '0);
    assign w_rel_eff   = r_rel   & ~((w_hs && r_type == EVT_RELEASE) ? w_chan_oh : '0);

`ifdef BUTTON_EVENT_LONGPRESS_EN
    localparam int LW = $clog2(C_LONG_CYCLES + 1);

    logic [C_CHANNELS-1:0] r_long;
    logic [C_CHANNELS-1:0] w_long_hit;

    for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_long
        logic [LW-1:0] r_cnt;

        // Hold timer: runs while the registered level is high, saturates, clears on release
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                r_cnt <= '0;
            end else if (!r_btn_q[gi]) begin
                r_cnt <= '0;
            end else if (r_cnt != LW'(C_LONG_CYCLES)) begin
                r_cnt <= r_cnt + LW'(1);
            end
        end

        // Fires exactly once per hold, on the edge the timer reaches the threshold
        assign w_long_hit[gi] = r_btn_q[gi] && (r_cnt == LW'(C_LONG_CYCLES - 1));
    end

    assign w_long_eff = r_long & ~((w_hs && r_type == EVT_LONG) ? w_chan_oh : '0);
    assign w_long_ovr = w_long_hit & w_long_eff;

    // Long-press pending bits: a new hit wins over a same-cycle acceptance
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_long <= '0;
        end else begin
            r_long <= w_long_eff | w_long_hit;
        end
    end
`else
    assign w_long_eff = '0;
    assign w_long_ovr = '0;
`endif

    assign w_req = w_press_eff | w_rel_eff | w_long_eff;

    rr_arbiter #(
        .C_CHANNELS (C_CHANNELS)
    ) u_rr_arbiter (
        .clk   (clk),
        .rstb  (rstb),
        .i_req (w_req),
        .i_en  (w_load),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Within the granted channel: press first, then long-press, then release
    assign w_sel_type = (|(w_press_eff & w_gnt)) ? EVT_PRESS :
                        (|(w_long_eff  & w_gnt)) ? EVT_LONG  : EVT_RELEASE;

    // A new edge onto a pending bit that is not being accepted loses an event
    assign w_ovr_set = (w_rise & w_press_eff) | (w_fall & w_rel_eff) | w_long_ovr;

    // Previous-cycle button levels for edge detection
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_btn_q <= '0;
        end else begin
            r_btn_q <= btn_in;
        end
    end

    // Press/release pending bits: set wins over a same-cycle acceptance
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_press <= '0;
            r_rel   <= '0;
        end else begin
            r_press <= w_press_eff | w_rise;
            r_rel   <= w_rel_eff | w_fall;
        end
    end

    // Output slot: reload when empty or being accepted, otherwise hold
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_type  <= EVT_PRESS;
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_chan <= w_idx;
                r_type <= w_sel_type;
            end
        end
    end

    // Sticky overrun flags; a new overrun beats a simultaneous clear
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ovr <= '0;
        end else begin
            r_ovr <= (ovr_clr ? '0 : r_ovr) | w_ovr_set;
        end
    end

    assign evt_valid = r_valid;
    assign evt_chan  = r_chan;
    assign evt_type  = r_type;
    assign overrun   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_event_arbiter
//  Brief    : Self-checking bench for button_event_arbiter (4 channels,
//             long-press threshold of 10 cycles when enabled).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_arbiter;

    localparam int N  = 4;
    localparam int LC = 10;

    logic         clk       = 1'b0;
    logic         rstb      = 1'b0;
    logic [N-1:0] btn_in    = '0;
    logic         evt_ready = 1'b1;
    logic         ovr_clr   = 1'b0;
    logic         evt_valid;
    logic [1:0]   evt_chan;
    logic [1:0]   evt_type;
    logic [N-1:0] overrun;

    int checks = 0;
    int errors = 0;

    button_event_arbiter #(
        .C_CHANNELS (N),
        .C_CLK_FRQ  (1000),
        .C_LONG_MS  (10)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .btn_in    (btn_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_chan  (evt_chan),
        .evt_type  (evt_type),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: per-channel pending flags as plain bit sets, a
    // "last served" channel number, and a single presented-event slot.
    // ------------------------------------------------------------------
    bit           m_valid = 0;
    int           m_chan  = 0;
    int           m_type  = 0;
    int           m_last  = N - 1;
    bit [N-1:0]   m_press = '0, m_rel = '0, m_long = '0, m_ovr = '0, m_q = '0;
    int           m_cnt [N];
    bit [N-1:0]   p, r, l, rise, fall, lhit, lost;
    bit           found;
    int           j;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_valid = 0; m_chan = 0; m_type = 0; m_last = N - 1;
            m_press = '0; m_rel = '0; m_long = '0; m_ovr = '0; m_q = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            p = m_press; r = m_rel; l = m_long;
            if (m_valid && evt_ready) begin
                if (m_type == 0) p[m_chan] = 0;
                else if (m_type == 1) r[m_chan] = 0;
                else l[m_chan] = 0;
            end
            if (!m_valid || evt_ready) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    j = (m_last + k) % N;
                    if (!found && (p[j] || r[j] || l[j])) begin
                        found  = 1;
                        m_chan = j;
                        m_type = p[j] ? 0 : (l[j] ? 2 : 1);
                        m_last = j;
                    end
                end
                m_valid = found;
            end
            rise = btn_in & ~m_q;
            fall = ~btn_in & m_q;
            lhit = '0;
`ifdef BUTTON_EVENT_LONGPRESS_EN
            for (int i = 0; i < N; i++) begin
                if (m_q[i]) begin
                    if (m_cnt[i] < LC) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == LC) lhit[i] = 1;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
            end
`endif
            lost    = (rise & p) | (fall & r) | (lhit & l);
            m_press = p | rise;
            m_rel   = r | fall;
            m_long  = l | lhit;
            m_ovr   = (ovr_clr ? '0 : m_ovr) | lost;
            m_q     = btn_in;
        end
    end

    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit v, input int c, input int t, input bit [N-1:0] o);
        check({tag, ".valid"}, 32'(evt_valid), 32'(v));
        if (v) begin
            check({tag, ".chan"}, 32'(evt_chan), 32'(c));
            check({tag, ".type"}, 32'(evt_type), 32'(t));
        end
        check({tag, ".ovr"}, 32'(overrun), 32'(o));
    endtask

    typedef struct {
        logic [N-1:0] btn;
        logic         rdy;
        logic         clr;
        logic         valid;
        int           chan;
        int           typ;
        logic [N-1:0] ovr;
    } vec_t;

    vec_t tbl [12];
    int   seen [$];
    int   exp_seq [$];

    initial begin
        // All four buttons pressed together, then released together
        tbl[0]  = '{4'b0000, 1, 0, 0, 0, 0, 4'b0000};
        tbl[1]  = '{4'b1111, 1, 0, 0, 0, 0, 4'b0000};
        tbl[2]  = '{4'b1111, 1, 0, 1, 0, 0, 4'b0000};
        tbl[3]  = '{4'b1111, 1, 0, 1, 1, 0, 4'b0000};
        tbl[4]  = '{4'b1111, 1, 0, 1, 2, 0, 4'b0000};
        tbl[5]  = '{4'b1111, 1, 0, 1, 3, 0, 4'b0000};
        tbl[6]  = '{4'b0000, 1, 0, 0, 0, 0, 4'b0000};
        tbl[7]  = '{4'b0000, 1, 0, 1, 0, 1, 4'b0000};
        tbl[8]  = '{4'b0000, 1, 0, 1, 1, 1, 4'b0000};
        tbl[9]  = '{4'b0000, 1, 0, 1, 2, 1, 4'b0000};
        tbl[10] = '{4'b0000, 1, 0, 1, 3, 1, 4'b0000};
        tbl[11] = '{4'b0000, 1, 0, 0, 0, 0, 4'b0000};

        // Reset state
        rstb = 1'b0;
        step(); step();
        check("rst.valid", 32'(evt_valid), 0);
        check("rst.chan",  32'(evt_chan),  0);
        check("rst.type",  32'(evt_type),  0);
        check("rst.ovr",   32'(overrun),   0);
        rstb = 1'b1;

        // Table-driven burst press / release
        for (int i = 0; i < 12; i++) begin
            btn_in = tbl[i].btn; evt_ready = tbl[i].rdy; ovr_clr = tbl[i].clr;
            step();
            expect_out($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].chan, tbl[i].typ, tbl[i].ovr);
        end

        // Single press: two-cycle latency, then release
        btn_in = 4'b0001;
        step(); expect_out("lat.e1", 0, 0, 0, 4'b0000);
        step(); expect_out("lat.e2", 1, 0, 0, 4'b0000);
        btn_in = 4'b0000;
        step(); expect_out("lat.e3", 0, 0, 0, 4'b0000);
        step(); expect_out("lat.e4", 1, 0, 1, 4'b0000);
        step(); expect_out("lat.e5", 0, 0, 0, 4'b0000);

        // Stall on channel 2, toggle it to provoke an overrun, clear it, drain
        evt_ready = 1'b0; btn_in = 4'b0100;
        step(); expect_out("ovr.e1", 0, 0, 0, 4'b0000);
        step(); expect_out("ovr.e2", 1, 2, 0, 4'b0000);
        btn_in = 4'b0000;
        step(); expect_out("ovr.e3", 1, 2, 0, 4'b0000);
        btn_in = 4'b0100;
        step(); expect_out("ovr.e4", 1, 2, 0, 4'b0100);
        ovr_clr = 1'b1;
        step(); expect_out("ovr.e5", 1, 2, 0, 4'b0000);
        ovr_clr = 1'b0; evt_ready = 1'b1;
        step(); expect_out("ovr.e6", 1, 2, 1, 4'b0000);
        step(); expect_out("ovr.e7", 0, 0, 0, 4'b0000);
        btn_in = 4'b0000;
        step(); expect_out("ovr.e8", 0, 0, 0, 4'b0000);
        step(); expect_out("ovr.e9", 1, 2, 1, 4'b0000);
        step(); expect_out("ovr.e10", 0, 0, 0, 4'b0000);

        // Hold channel 1 for 12 cycles and collect the accepted events
        btn_in = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) btn_in = 4'b0000;
            step();
            if (evt_valid && evt_ready && evt_chan == 2'd1) seen.push_back(int'(evt_type));
        end
`ifdef BUTTON_EVENT_LONGPRESS_EN
        exp_seq = '{0, 2, 1};
`else
        exp_seq = '{0, 1};
`endif
        check("long.count", 32'(seen.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < seen.size(); i++)
            check($sformatf("long.evt%0d", i), 32'(seen[i]), 32'(exp_seq[i]));

        // Asynchronous reset while an event is presented
        evt_ready = 1'b0; btn_in = 4'b1111;
        step(); step();
        check("arst.pre_valid", 32'(evt_valid), 1);
        rstb = 1'b0; btn_in = 4'b0010;
        #1;
        check("arst.valid", 32'(evt_valid), 0);
        check("arst.ovr",   32'(overrun),   0);
        step();
        rstb = 1'b1; evt_ready = 1'b1;
        step(); expect_out("arst.e1", 0, 0, 0, 4'b0000);
        step(); expect_out("arst.e2", 1, 1, 0, 4'b0000);
        step(); expect_out("arst.e3", 0, 0, 0, 4'b0000);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) btn_in[b] = ~btn_in[b];
            evt_ready = ($urandom_range(0, 3) != 0);
            ovr_clr   = ($urandom_range(0, 15) == 0);
            step();
            check($sformatf("rnd%0d.valid", i), 32'(evt_valid), 32'(m_valid));
            if (m_valid) begin
                check($sformatf("rnd%0d.chan", i), 32'(evt_chan), 32'(m_chan));
                check($sformatf("rnd%0d.type", i), 32'(evt_type), 32'(m_type));
            end
            check($sformatf("rnd%0d.ovr", i), 32'(overrun), 32'(m_ovr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
